// File: rtl/not_not_game_fsm.sv
// Round sequencer for the Not Not game: starts rounds, advances the prompt LFSRs,
// times the player's response, judges key presses and keeps score / high score.
module not_not_game_fsm #(
    parameter int ROUND_CYCLES = 100_000_000,
    parameter int TIMER_W      = 27
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] key_n,
    input  logic [3:0] target,
    input  logic       done_draw,
    output logic       lfsr_enable,
    output logic       draw_start,
    output logic       draw_lose,
    output logic       playing,
    output logic [7:0] score,
    output logic [7:0] highscore,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NEXT  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_PLAY  = 3'd4;
    localparam logic [2:0] S_LOSE  = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [3:0]         key_prev_q, key_prev_d;
    logic [3:0]         target_q, target_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         score_q, score_d;
    logic [7:0]         highscore_q, highscore_d;
    logic               draw_start_q, draw_start_d;
    logic               draw_lose_q, draw_lose_d;

    logic [3:0] down;
    logic [3:0] press;
    logic       press_any;
    logic       press_wrong;
    logic       timeout;
    logic [7:0] score_inc;
    logic       round_won;
    logic       round_lost;

    // A key counts once, on the cycle it goes down.
    assign down        = ~key_n;
    assign press       = down & ~key_prev_q;
    assign press_any   = (press != 4'b0000);
    assign press_wrong = ((press & ~target_q) != 4'b0000);
    assign timeout     = (timer_q == TIMER_LAST);
    assign score_inc   = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        key_prev_d   = down;
        target_d     = target_q;
        timer_d      = timer_q;
        score_d      = score_q;
        highscore_d  = highscore_q;
        draw_start_d = 1'b0;
        draw_lose_d  = 1'b0;
        round_won    = 1'b0;
        round_lost   = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (press_any) begin
                    state_d = S_NEXT;
                    score_d = 8'd0;
                end
            end
            S_NEXT: state_d = S_LATCH;
            S_LATCH: begin
                target_d     = target;
                state_d      = S_DRAW;
                draw_start_d = 1'b1;
            end
            S_DRAW: begin
                if (done_draw) begin
                    state_d = S_PLAY;
                    timer_d = '0;
                end
            end
            S_PLAY: begin
                timer_d = timer_q + TIMER_W'(1);
                // A press always beats the timeout, even in the last cycle of the window.
                if (press_any) begin
                    round_won  = !press_wrong;
                    round_lost = press_wrong;
                end else if (timeout) begin
                    round_won  = (target_q == 4'b0000);
                    round_lost = (target_q != 4'b0000);
                end
                if (round_won) begin
                    state_d = S_NEXT;
                    score_d = score_inc;
                    if (score_inc > highscore_q) highscore_d = score_inc;
                end else if (round_lost) begin
                    state_d     = S_LOSE;
                    draw_lose_d = 1'b1;
                end
            end
            S_LOSE: begin
                if (done_draw) state_d = S_OVER;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            state_q      <= S_IDLE;
            key_prev_q   <= 4'b0000;
            target_q     <= 4'b0000;
            timer_q      <= '0;
            score_q      <= 8'd0;
            highscore_q  <= 8'd0;
            draw_start_q <= 1'b0;
            draw_lose_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_prev_q   <= key_prev_d;
            target_q     <= target_d;
            timer_q      <= timer_d;
            score_q      <= score_d;
            highscore_q  <= highscore_d;
            draw_start_q <= draw_start_d;
            draw_lose_q  <= draw_lose_d;
        end
    end

    assign lfsr_enable = (state_q == S_NEXT);
    assign playing     = (state_q == S_PLAY);
    assign draw_start  = draw_start_q;
    assign draw_lose   = draw_lose_q;
    assign score       = score_q;
    assign highscore   = highscore_q;
    assign state       = state_q;

endmodule

// File: tb/tb_not_not_game_fsm.sv
// Scenario-driven bench for not_not_game_fsm; expected score/high score come from a
// round-level game model, expected timing from the documented cycle latencies.
module tb_not_not_game_fsm;

    localparam int ROUND_CYCLES = 16;
    localparam int TIMER_W      = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_NEXT  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_PLAY  = 3'd4;
    localparam logic [2:0] ST_LOSE  = 3'd5;
    localparam logic [2:0] ST_OVER  = 3'd6;

    logic       clock     = 1'b0;
    logic       resetn    = 1'b0;
    logic [3:0] key_n     = 4'hF;
    logic [3:0] target    = 4'h0;
    logic       done_draw = 1'b0;
    logic       lfsr_enable;
    logic       draw_start;
    logic       draw_lose;
    logic       playing;
    logic [7:0] score;
    logic [7:0] highscore;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    // Game model: score and best score since reset.
    logic [7:0] exp_score = 8'd0;
    logic [7:0] exp_high  = 8'd0;

    not_not_game_fsm #(
        .ROUND_CYCLES(ROUND_CYCLES),
        .TIMER_W     (TIMER_W)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .key_n      (key_n),
        .target     (target),
        .done_draw  (done_draw),
        .lfsr_enable(lfsr_enable),
        .draw_start (draw_start),
        .draw_lose  (draw_lose),
        .playing    (playing),
        .score      (score),
        .highscore  (highscore),
        .state      (state)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    // A round is won if the press contains only answer keys, or if there is no
    // press and the answer mask is empty.
    function automatic bit is_correct(input logic [3:0] pressed, input logic [3:0] tgt);
        if (pressed == 4'b0000) return (tgt == 4'b0000);
        return ((pressed & ~tgt) == 4'b0000);
    endfunction

    function automatic logic [3:0] rand_subset(input logic [3:0] tgt);
        logic [3:0] low;
        low = tgt & (~tgt + 4'd1);
        return (4'($urandom) & tgt) | low;
    endfunction

    task automatic model_credit();
        if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
        if (exp_score > exp_high) exp_high = exp_score;
    endtask

    // Precondition: current cycle is S_NEXT. Ends in the first S_PLAY cycle.
    task automatic run_to_play(input logic [3:0] tgt, input int draw_wait, input logic [3:0] draw_keys);
        target = tgt;
        n_checks++;
        if (state !== ST_NEXT || lfsr_enable !== 1'b1 || draw_start !== 1'b0)
            $display("FAIL next_state: state=%0d lfsr_enable=%b draw_start=%b, want 1/1/0", state, lfsr_enable, draw_start);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (state !== ST_LATCH || lfsr_enable !== 1'b0 || draw_start !== 1'b0)
            $display("FAIL latch_state: state=%0d lfsr_enable=%b draw_start=%b, want 2/0/0", state, lfsr_enable, draw_start);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (state !== ST_DRAW || draw_start !== 1'b1 || lfsr_enable !== 1'b0 || draw_lose !== 1'b0)
            $display("FAIL draw_start_pulse: state=%0d draw_start=%b lfsr_enable=%b draw_lose=%b, want 3/1/0/0", state, draw_start, lfsr_enable, draw_lose);
        else n_pass++;
        // The answer mask must already be captured; scramble the live input.
        target = 4'($urandom);
        key_n  = ~draw_keys;
        for (int i = 0; i < draw_wait; i++) begin
            next_cycle();
            n_checks++;
            if (state !== ST_DRAW || draw_start !== 1'b0)
                $display("FAIL draw_wait: state=%0d draw_start=%b, want 3/0", state, draw_start);
            else n_pass++;
        end
        done_draw = 1'b1;
        next_cycle();
        done_draw = 1'b0;
        n_checks++;
        if (state !== ST_PLAY || playing !== 1'b1 || draw_start !== 1'b0)
            $display("FAIL enter_play: state=%0d playing=%b draw_start=%b, want 4/1/0", state, playing, draw_start);
        else n_pass++;
    endtask

    // Precondition: PLAY cycle 0. Presses keys in PLAY cycle k, releases afterwards.
    task automatic play_press(input int k, input logic [3:0] keys, input bit noise);
        for (int i = 0; i < k; i++) begin
            if (noise) done_draw = 1'($urandom_range(0, 1));
            next_cycle();
            done_draw = 1'b0;
            n_checks++;
            if (state !== ST_PLAY || playing !== 1'b1)
                $display("FAIL play_wait: state=%0d playing=%b at cycle %0d, want 4/1", state, playing, i + 1);
            else n_pass++;
        end
        key_n = ~keys;
        next_cycle();
        key_n = 4'hF;
    endtask

    // Precondition: PLAY cycle 0. Lets the whole window run out without a new press.
    task automatic play_timeout(input bit noise);
        for (int i = 0; i < ROUND_CYCLES - 1; i++) begin
            if (noise) done_draw = 1'($urandom_range(0, 1));
            next_cycle();
            done_draw = 1'b0;
            n_checks++;
            if (state !== ST_PLAY)
                $display("FAIL window_open: state=%0d at play cycle %0d, want 4", state, i + 1);
            else n_pass++;
        end
        next_cycle();
    endtask

    task automatic expect_outcome(input logic [3:0] pressed, input logic [3:0] tgt, output bit won);
        won = is_correct(pressed, tgt);
        if (won) begin
            model_credit();
            n_checks++;
            if (state !== ST_NEXT || lfsr_enable !== 1'b1 || draw_lose !== 1'b0)
                $display("FAIL win_state: state=%0d lfsr_enable=%b draw_lose=%b, want 1/1/0 (press=%b target=%b)", state, lfsr_enable, draw_lose, pressed, tgt);
            else n_pass++;
        end else begin
            n_checks++;
            if (state !== ST_LOSE || draw_lose !== 1'b1 || lfsr_enable !== 1'b0)
                $display("FAIL lose_state: state=%0d draw_lose=%b lfsr_enable=%b, want 5/1/0 (press=%b target=%b)", state, draw_lose, lfsr_enable, pressed, tgt);
            else n_pass++;
        end
        n_checks++;
        if (score !== exp_score || highscore !== exp_high)
            $display("FAIL score: score=%0d highscore=%0d, want %0d/%0d", score, highscore, exp_score, exp_high);
        else n_pass++;
    endtask

    // Precondition: first S_LOSE cycle. Ends in S_OVER.
    task automatic finish_lose(input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            next_cycle();
            n_checks++;
            if (state !== ST_LOSE || draw_lose !== 1'b0)
                $display("FAIL lose_wait: state=%0d draw_lose=%b, want 5/0", state, draw_lose);
            else n_pass++;
        end
        done_draw = 1'b1;
        next_cycle();
        n_checks++;
        if (state !== ST_OVER || score !== exp_score)
            $display("FAIL game_over: state=%0d score=%0d, want 6/%0d", state, score, exp_score);
        else n_pass++;
        // A stray done_draw in S_OVER changes nothing.
        next_cycle();
        done_draw = 1'b0;
        n_checks++;
        if (state !== ST_OVER || score !== exp_score)
            $display("FAIL over_hold: state=%0d score=%0d, want 6/%0d", state, score, exp_score);
        else n_pass++;
    endtask

    task automatic restart(input logic [3:0] keys);
        key_n = ~keys;
        next_cycle();
        key_n = 4'hF;
        exp_score = 8'd0;
        n_checks++;
        if (state !== ST_NEXT || lfsr_enable !== 1'b1 || score !== 8'd0 || highscore !== exp_high)
            $display("FAIL restart: state=%0d lfsr_enable=%b score=%0d highscore=%0d, want 1/1/0/%0d", state, lfsr_enable, score, highscore, exp_high);
        else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) next_cycle();
        n_checks++;
        if (state !== ST_IDLE || score !== 8'd0 || highscore !== 8'd0)
            $display("FAIL reset_regs: state=%0d score=%0d highscore=%0d, want 0/0/0", state, score, highscore);
        else n_pass++;
        n_checks++;
        if ({lfsr_enable, draw_start, draw_lose, playing} !== 4'b0000)
            $display("FAIL reset_pulses: lfsr/draw_start/draw_lose/playing=%b, want 0000", {lfsr_enable, draw_start, draw_lose, playing});
        else n_pass++;
        resetn = 1'b1;
        next_cycle();
        n_checks++;
        if (state !== ST_IDLE)
            $display("FAIL idle_hold: state=%0d, want 0", state);
        else n_pass++;
    endtask

    task automatic test_start();
        key_n = 4'b1110;
        next_cycle();
        key_n = 4'hF;
        n_checks++;
        if (score !== 8'd0 || lfsr_enable !== 1'b1)
            $display("FAIL start: score=%0d lfsr_enable=%b, want 0/1", score, lfsr_enable);
        else n_pass++;
        run_to_play(4'b0100, 2, 4'b0000);
    endtask

    task automatic test_correct_press();
        bit won;
        play_press(5, 4'b0100, 1'b0);
        expect_outcome(4'b0100, 4'b0100, won);
    endtask

    task automatic test_wrong_press();
        bit won;
        run_to_play(4'b0111, 1, 4'b0000);
        play_press(2, 4'b1000, 1'b0);
        expect_outcome(4'b1000, 4'b0111, won);
        finish_lose(2);
        restart(4'b0001);
    endtask

    task automatic test_timeout();
        bit won;
        run_to_play(4'b0000, 0, 4'b0000);
        play_timeout(1'b0);
        expect_outcome(4'b0000, 4'b0000, won);
        run_to_play(4'b0010, 0, 4'b0000);
        play_timeout(1'b0);
        expect_outcome(4'b0000, 4'b0010, won);
        finish_lose(0);
        restart(4'b0100);
        // Presses in the very last window cycle beat the timeout.
        run_to_play(4'b0010, 0, 4'b0000);
        play_press(ROUND_CYCLES - 1, 4'b0010, 1'b0);
        expect_outcome(4'b0010, 4'b0010, won);
        run_to_play(4'b0000, 1, 4'b0000);
        play_press(ROUND_CYCLES - 1, 4'b0001, 1'b0);
        expect_outcome(4'b0001, 4'b0000, won);
        finish_lose(1);
        restart(4'b0010);
    endtask

    task automatic test_held_key();
        bit won;
        run_to_play(4'b0010, 1, 4'b0010);
        play_timeout(1'b0);
        key_n = 4'hF;
        expect_outcome(4'b0000, 4'b0010, won);
        finish_lose(1);
        restart(4'b1000);
    endtask

    task automatic test_multi_key();
        bit won;
        run_to_play(4'b0010, 0, 4'b0000);
        play_press(4, 4'b0110, 1'b0);
        expect_outcome(4'b0110, 4'b0010, won);
        finish_lose(3);
        restart(4'b0001);
    endtask

    task automatic test_random_rounds(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            logic [3:0] tgt;
            logic [3:0] keys;
            int         mode;
            bit         won;
            tgt = 4'($urandom);
            run_to_play(tgt, $urandom_range(0, 3), 4'b0000);
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                keys = 4'b0000;
                play_timeout(1'b1);
            end else begin
                if (mode == 1 && tgt != 4'b0000) keys = rand_subset(tgt);
                else keys = 4'($urandom_range(1, 15));
                play_press($urandom_range(0, ROUND_CYCLES - 1), keys, 1'b1);
            end
            expect_outcome(keys, tgt, won);
            if (!won) begin
                finish_lose($urandom_range(0, 3));
                restart(4'($urandom_range(1, 15)));
            end
        end
    endtask

    task automatic test_saturation();
        bit won;
        logic [3:0] tgt;
        logic [3:0] keys;
        while (exp_score != 8'hFF) begin
            tgt  = 4'($urandom_range(1, 15));
            keys = rand_subset(tgt);
            run_to_play(tgt, 0, 4'b0000);
            play_press(0, keys, 1'b0);
            expect_outcome(keys, tgt, won);
        end
        run_to_play(4'b1000, 0, 4'b0000);
        play_press(1, 4'b1000, 1'b0);
        expect_outcome(4'b1000, 4'b1000, won);
        n_checks++;
        if (score !== 8'd255 || highscore !== 8'd255)
            $display("FAIL saturate: score=%0d highscore=%0d, want 255/255", score, highscore);
        else n_pass++;
    endtask

    task automatic test_reset_mid_draw();
        next_cycle();
        next_cycle();
        n_checks++;
        if (state !== ST_DRAW)
            $display("FAIL pre_reset_draw: state=%0d, want 3", state);
        else n_pass++;
        resetn    = 1'b0;
        done_draw = 1'b1;
        next_cycle();
        exp_score = 8'd0;
        exp_high  = 8'd0;
        n_checks++;
        if (state !== ST_IDLE || score !== 8'd0 || highscore !== 8'd0 ||
            {lfsr_enable, draw_start, draw_lose, playing} !== 4'b0000)
            $display("FAIL reset_mid_draw: state=%0d score=%0d highscore=%0d pulses=%b, want 0/0/0/0000",
                     state, score, highscore, {lfsr_enable, draw_start, draw_lose, playing});
        else n_pass++;
        resetn = 1'b1;
        next_cycle();
        done_draw = 1'b0;
        n_checks++;
        if (state !== ST_IDLE || playing !== 1'b0)
            $display("FAIL reset_drop_done: state=%0d playing=%b, want 0/0", state, playing);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_correct_press();
        test_wrong_press();
        test_timeout();
        test_held_key();
        test_multi_key();
        test_random_rounds(40);
        test_saturation();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
